// File: rtl/nv_assert_report_arb.sv
// Serialises assertion-checker violations onto one valid/ready report channel, with arming delay, report limit and counters.
// Optional build macro NV_ASSERT_ARB_FATAL_EN: sticky fatal flag that also overrides assert_off once the limit is reached.
module nv_assert_report_arb #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_REPORT   = 16,
    parameter int unsigned START_CYCLES = 8,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned IDW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic               assert_off,
    input  logic [NREQ-1:0]    viol_vld,
    input  logic [NREQ*DW-1:0] viol_data,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [IDW-1:0]     rpt_id,
    output logic [DW-1:0]      rpt_data,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   drop_count,
    output logic               armed,
    output logic               limit_hit,
    output logic               fatal
);

    typedef enum logic [1:0] {ST_ARM, ST_RUN, ST_LIMIT} state_t;

    localparam int unsigned    ACW         = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam int unsigned    LCW         = $clog2(MAX_REPORT + 1);
    localparam logic [ACW-1:0] ARM_LAST    = ACW'((START_CYCLES > 0) ? START_CYCLES - 1 : 0);
    localparam logic [LCW-1:0] LOAD_LAST   = LCW'(MAX_REPORT - 1);
    localparam logic [LCW-1:0] LOAD_MAX    = LCW'(MAX_REPORT);
    localparam state_t         RESET_STATE = (START_CYCLES == 0) ? ST_RUN : ST_ARM;
    localparam logic [63:0]    CNT_MAX     = (64'd1 << CNT_W) - 64'd1;

    state_t            state, state_nxt;
    logic [ACW-1:0]    arm_cnt;
    logic [LCW-1:0]    load_cnt;
    logic [IDW-1:0]    ptr, grant;
    logic              grant_vld, load, enter_limit, off_eff;
    logic [NREQ-1:0]   pend, pend_nxt, latch, drop, acc;
    logic [DW-1:0]     slot_data [NREQ];
    int unsigned       drop_inc;

    function automatic int unsigned popcnt(input logic [NREQ-1:0] v);
        int unsigned n = 0;
        for (int unsigned i = 0; i < NREQ; i++)
            if (v[i]) n++;
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input int unsigned inc);
        logic [63:0] s;
        s = 64'(a) + 64'(inc);
        return (s > CNT_MAX) ? '1 : CNT_W'(s);
    endfunction

`ifdef NV_ASSERT_ARB_FATAL_EN
    assign off_eff = assert_off & ~fatal;
`else
    assign off_eff = assert_off;
`endif

    assign acc       = (state == ST_ARM || off_eff) ? '0 : viol_vld;
    assign armed     = (state != ST_ARM);
    assign limit_hit = (state == ST_LIMIT);

    // Round-robin search starts one past the last granted index.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!grant_vld && pend[IDW'((32'(ptr) + k) % NREQ)]) begin
                grant_vld = 1'b1;
                grant     = IDW'((32'(ptr) + k) % NREQ);
            end
        end
    end

    assign load        = (~rpt_valid | rpt_ready) & grant_vld & (load_cnt < LOAD_MAX);
    assign enter_limit = (state == ST_RUN) && load && (load_cnt == LOAD_LAST);

    always_comb begin
        pend_nxt = pend;
        latch    = '0;
        drop     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (load && grant == IDW'(i))
                pend_nxt[i] = 1'b0;
            if (acc[i]) begin
                if (state == ST_RUN && (!pend[i] || (load && grant == IDW'(i)))) begin
                    latch[i]    = 1'b1;
                    pend_nxt[i] = 1'b1;
                end else begin
                    drop[i] = 1'b1;
                end
            end
        end
        // Slots left over (including ones refilled on this edge) are discarded in one add.
        drop_inc = popcnt(drop) + (enter_limit ? popcnt(pend_nxt) : 0);
        if (enter_limit)
            pend_nxt = '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARM:   if (arm_cnt == ARM_LAST) state_nxt = ST_RUN;
            ST_RUN:   if (enter_limit) state_nxt = ST_LIMIT;
            default:  state_nxt = ST_LIMIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state      <= RESET_STATE;
            arm_cnt    <= '0;
            load_cnt   <= '0;
            ptr        <= '0;
            pend       <= '0;
            err_count  <= '0;
            drop_count <= '0;
            rpt_valid  <= 1'b0;
            rpt_id     <= '0;
            rpt_data   <= '0;
            for (int unsigned i = 0; i < NREQ; i++)
                slot_data[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_ARM)
                arm_cnt <= arm_cnt + ACW'(1);
            pend       <= pend_nxt;
            err_count  <= sat_add(err_count, popcnt(acc));
            drop_count <= sat_add(drop_count, drop_inc);
            for (int unsigned i = 0; i < NREQ; i++)
                if (latch[i])
                    slot_data[i] <= viol_data[i*DW +: DW];
            if (load) begin
                rpt_valid <= 1'b1;
                rpt_id    <= grant;
                rpt_data  <= slot_data[grant];
                ptr       <= grant;
                load_cnt  <= load_cnt + LCW'(1);
            end else if (rpt_ready) begin
                rpt_valid <= 1'b0;
            end
        end
    end

`ifdef NV_ASSERT_ARB_FATAL_EN
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)
            fatal <= 1'b0;
        else if (state == ST_LIMIT)
            fatal <= 1'b1;
    end
`else
    assign fatal = 1'b0;
`endif

endmodule

// File: tb/tb_nv_assert_report_arb.sv
// Directed self-checking bench for nv_assert_report_arb with default parameters.
module tb_nv_assert_report_arb;

    logic         clk = 1'b0;
    logic         reset_, assert_off, rpt_ready;
    logic [3:0]   viol_vld;
    logic [127:0] viol_data;
    logic         rpt_valid, armed, limit_hit, fatal;
    logic [1:0]   rpt_id;
    logic [31:0]  rpt_data, last_data;
    logic [15:0]  err_count, drop_count;
    int           checks   = 0;
    int           failures = 0;
    int           rpt_seen;

    logic [1:0]  exp_id   [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] exp_data [4] = '{32'h11, 32'h12, 32'h13, 32'h10};

    always #5 clk = ~clk;

    nv_assert_report_arb #(
        .NREQ(4), .DW(32), .MAX_REPORT(16), .START_CYCLES(8), .CNT_W(16)
    ) dut (
        .clk(clk), .reset_(reset_), .assert_off(assert_off),
        .viol_vld(viol_vld), .viol_data(viol_data),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_id(rpt_id), .rpt_data(rpt_data),
        .err_count(err_count), .drop_count(drop_count),
        .armed(armed), .limit_hit(limit_hit), .fatal(fatal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_ = 1'b0; assert_off = 1'b0; rpt_ready = 1'b1;
        viol_vld = '0; viol_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(rpt_valid), 64'd0);
        check("rst_err",   64'(err_count), 64'd0);
        check("rst_drop",  64'(drop_count), 64'd0);
        check("rst_armed", 64'(armed), 64'd0);
        check("rst_limit", 64'(limit_hit), 64'd0);
        check("rst_fatal", 64'(fatal), 64'd0);
        reset_ = 1'b1;

        // Arming window: cycle-3 event ignored, armed after edge 8, cycle-9 event reported.
        step(); step();
        viol_vld = 4'b0001; viol_data[31:0] = 32'hAB;
        step();
        viol_vld = '0;
        repeat (4) step();
        check("arm_pre", 64'(armed), 64'd0);
        step();
        check("arm_rise", 64'(armed), 64'd1);
        check("arm_err",  64'(err_count), 64'd0);
        viol_vld = 4'b0001; viol_data[31:0] = 32'hCD;
        step();
        viol_vld = '0;
        check("run_err1", 64'(err_count), 64'd1);
        check("run_lat",  64'(rpt_valid), 64'd0);
        step();
        check("run_valid", 64'(rpt_valid), 64'd1);
        check("run_id",    64'(rpt_id), 64'd0);
        check("run_data",  64'(rpt_data), 64'hCD);
        step();
        check("run_idle", 64'(rpt_valid), 64'd0);

        // All four fire together: round robin order 1,2,3,0.
        viol_vld = 4'b1111;
        for (int i = 0; i < 4; i++) viol_data[i*32 +: 32] = 32'h10 + 32'(i);
        step();
        viol_vld = '0;
        check("rr_err", 64'(err_count), 64'd5);
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_valid", 64'(rpt_valid), 64'd1);
            check("rr_id",    64'(rpt_id), 64'(exp_id[k]));
            check("rr_data",  64'(rpt_data), 64'(exp_data[k]));
        end
        step();
        check("rr_idle", 64'(rpt_valid), 64'd0);

        // Backpressure: held report, refilled slot, then a dropped event.
        rpt_ready = 1'b0;
        viol_vld = 4'b0100; viol_data[64 +: 32] = 32'h21;
        step();
        viol_data[64 +: 32] = 32'h22;
        step();
        check("bp_valid", 64'(rpt_valid), 64'd1);
        check("bp_id",    64'(rpt_id), 64'd2);
        check("bp_data",  64'(rpt_data), 64'h21);
        viol_data[64 +: 32] = 32'h23;
        step();
        viol_vld = '0;
        check("bp_drop", 64'(drop_count), 64'd1);
        repeat (3) step();
        check("bp_hold_v", 64'(rpt_valid), 64'd1);
        check("bp_hold_d", 64'(rpt_data), 64'h21);
        check("bp_err",    64'(err_count), 64'd8);
        rpt_ready = 1'b1;
        step();
        check("bp_next_id",   64'(rpt_id), 64'd2);
        check("bp_next_data", 64'(rpt_data), 64'h22);
        step();
        check("bp_idle", 64'(rpt_valid), 64'd0);

        // assert_off in RUN masks everything.
        assert_off = 1'b1; viol_vld = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            step();
            check("off_run_valid", 64'(rpt_valid), 64'd0);
        end
        viol_vld = '0; assert_off = 1'b0;
        step(); step();
        check("off_run_valid2", 64'(rpt_valid), 64'd0);
        check("off_run_err",    64'(err_count), 64'd8);
        check("off_run_drop",   64'(drop_count), 64'd1);

        // Seven reports so far; 13 pulses from checker 1 yield 9 more then LIMIT.
        rpt_seen = 0; last_data = '0;
        for (int p = 1; p <= 13; p++) begin
            viol_vld = 4'b0010; viol_data[32 +: 32] = 32'(p);
            step();
            if (rpt_valid) begin rpt_seen++; last_data = rpt_data; end
        end
        viol_vld = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (rpt_valid) begin rpt_seen++; last_data = rpt_data; end
        end
        check("lim_reports", 64'(rpt_seen), 64'd9);
        check("lim_last",    64'(last_data), 64'd9);
        check("lim_hit",     64'(limit_hit), 64'd1);
        check("lim_err",     64'(err_count), 64'd21);
        check("lim_drop",    64'(drop_count), 64'd5);
        check("lim_valid",   64'(rpt_valid), 64'd0);

        // assert_off while in LIMIT.
        assert_off = 1'b1; viol_vld = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            step();
            check("off_lim_valid", 64'(rpt_valid), 64'd0);
        end
        viol_vld = '0; assert_off = 1'b0;
        step();
`ifdef NV_ASSERT_ARB_FATAL_EN
        check("off_lim_err",   64'(err_count), 64'd27);
        check("off_lim_drop",  64'(drop_count), 64'd11);
        check("off_lim_fatal", 64'(fatal), 64'd1);
`else
        check("off_lim_err",   64'(err_count), 64'd21);
        check("off_lim_drop",  64'(drop_count), 64'd5);
        check("off_lim_fatal", 64'(fatal), 64'd0);
`endif

        // Asynchronous reset in the middle of a stalled transfer.
        reset_ = 1'b0;
        step();
        reset_ = 1'b1;
        repeat (8) step();
        check("rr2_armed", 64'(armed), 64'd1);
        check("rr2_limit", 64'(limit_hit), 64'd0);
        rpt_ready = 1'b0;
        viol_vld = 4'b0001; viol_data[31:0] = 32'h55;
        step();
        viol_vld = '0;
        step();
        check("ar_valid_pre", 64'(rpt_valid), 64'd1);
        check("ar_data_pre",  64'(rpt_data), 64'h55);
        check("ar_err_pre",   64'(err_count), 64'd1);
        #3 reset_ = 1'b0;
        #1;
        check("ar_valid", 64'(rpt_valid), 64'd0);
        check("ar_err",   64'(err_count), 64'd0);
        check("ar_drop",  64'(drop_count), 64'd0);
        check("ar_armed", 64'(armed), 64'd0);
        check("ar_fatal", 64'(fatal), 64'd0);
        step();
        reset_ = 1'b1;
        step();
        check("ar_post_valid", 64'(rpt_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
